// File: rtl/movegen_scheduler.sv
// movegen_scheduler: scans the packed board, dispatches pieces of the side to move to the
// move generator and stores returned moves in result RAM. Watchdog option: MOVEGEN_WATCHDOG_EN.
module movegen_scheduler #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 15,
   parameter int MOVE_BASE      = 16,
   parameter int MAX_MOVES      = 128,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  side,
   output logic [2:0]            board_addr,
   input  logic [DATA_WIDTH-1:0] board_rdata,
   output logic                  gen_req,
   output logic [5:0]            gen_square,
   output logic [3:0]            gen_piece,
   input  logic                  gen_ack,
   input  logic                  gen_move_valid,
   input  logic [5:0]            gen_move,
   input  logic                  gen_done,
   output logic                  res_we,
   output logic [ADDR_WIDTH-1:0] res_addr,
   output logic [DATA_WIDTH-1:0] res_wdata,
   output logic                  busy,
   output logic                  done,
   output logic [7:0]            move_count,
   output logic                  overflow,
   output logic                  timeout_err
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_WAIT, S_SCAN, S_REQ, S_COLLECT, S_DONE
   } state_t;

   localparam logic [7:0] MAX_CNT = 8'(MAX_MOVES);

   if (MAX_MOVES > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("movegen_scheduler: MAX_MOVES must fit in 8 bits and TIMEOUT_CYCLES must be >= 1");
   end

   state_t                state, state_nxt, step_state;
   logic [2:0]            word_idx, nib_idx;
   logic [DATA_WIDTH-1:0] board_word;
   logic                  side_q;
   logic [3:0]            nibble;
   logic                  own_piece, step, wd_fire;

   assign nibble     = board_word[{nib_idx, 2'b00} +: 4];
   assign own_piece  = (nibble != 4'd0) && (nibble[3] == side_q);
   assign step_state = (nib_idx != 3'd7) ? S_SCAN : (word_idx != 3'd7) ? S_FETCH : S_DONE;

   assign board_addr = word_idx;
   assign gen_req    = (state == S_REQ);
   assign gen_square = (state == S_REQ) ? {word_idx, nib_idx} : 6'd0;
   assign gen_piece  = (state == S_REQ) ? nibble : 4'd0;
   assign busy       = (state != S_IDLE) && (state != S_DONE);

`ifdef MOVEGEN_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_cnt;
   logic            wd_active, wd_kick;

   assign wd_active = (state == S_REQ) || (state == S_COLLECT);
   assign wd_kick   = ((state == S_REQ) && gen_ack) ||
                      ((state == S_COLLECT) && (gen_move_valid || gen_done));
   assign wd_fire   = wd_active && !wd_kick && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset || abort || !wd_active || wd_kick || wd_fire) wd_cnt <= '0;
      else                                                   wd_cnt <= wd_cnt + 1'b1;
   end
`else
   assign wd_fire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      step      = 1'b0;
      if (abort) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:    if (start) state_nxt = S_FETCH;
            S_FETCH:   state_nxt = S_WAIT;
            S_WAIT:    state_nxt = S_SCAN;
            S_SCAN:    if (own_piece) state_nxt = S_REQ; else step = 1'b1;
            S_REQ:     if (gen_ack) state_nxt = S_COLLECT; else if (wd_fire) step = 1'b1;
            S_COLLECT: if (gen_done || wd_fire) step = 1'b1;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
         endcase
         if (step) state_nxt = step_state;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         word_idx    <= 3'd0;
         nib_idx     <= 3'd0;
         board_word  <= '0;
         side_q      <= 1'b0;
         res_we      <= 1'b0;
         res_addr    <= ADDR_WIDTH'(MOVE_BASE);
         res_wdata   <= '0;
         done        <= 1'b0;
         move_count  <= 8'd0;
         overflow    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         res_we <= 1'b0;
         if (abort) begin
            done <= 1'b0;
         end else begin
            case (state)
               S_IDLE: if (start) begin
                  side_q      <= side;
                  move_count  <= 8'd0;
                  overflow    <= 1'b0;
                  done        <= 1'b0;
                  timeout_err <= 1'b0;
                  word_idx    <= 3'd0;
                  nib_idx     <= 3'd0;
               end
               S_WAIT: begin
                  board_word <= board_rdata;
                  nib_idx    <= 3'd0;
               end
               S_COLLECT: if (gen_move_valid) begin
                  if (move_count < MAX_CNT) begin
                     res_we     <= 1'b1;
                     res_addr   <= ADDR_WIDTH'(MOVE_BASE) + ADDR_WIDTH'(move_count);
                     res_wdata  <= DATA_WIDTH'({nibble, word_idx, nib_idx, gen_move});
                     move_count <= move_count + 8'd1;
                  end else begin
                     overflow <= 1'b1;
                  end
               end
               default: ;
            endcase
            // Advance to the next square; the word index rolls over after the last nibble.
            if (step) begin
               nib_idx <= nib_idx + 3'd1;
               if (nib_idx == 3'd7) word_idx <= word_idx + 3'd1;
               if (step_state == S_DONE) done <= 1'b1;
            end
            if (wd_fire) timeout_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_movegen_scheduler.sv
// Self-checking bench for movegen_scheduler: board RAM and generator models plus a
// square-order reference model of requests and result writes.
module tb_movegen_scheduler;

   localparam int MOVE_BASE = 16;
   localparam int MAX_MOVES = 128;

   logic        clk = 1'b0;
   logic        reset, start, abort, side;
   logic [2:0]  board_addr;
   logic [31:0] board_rdata;
   logic        gen_req;
   logic [5:0]  gen_square;
   logic [3:0]  gen_piece;
   logic        gen_ack, gen_move_valid, gen_done;
   logic [5:0]  gen_move;
   logic        res_we;
   logic [14:0] res_addr;
   logic [31:0] res_wdata;
   logic        busy, done, overflow, timeout_err;
   logic [7:0]  move_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   movegen_scheduler dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .side(side),
      .board_addr(board_addr), .board_rdata(board_rdata),
      .gen_req(gen_req), .gen_square(gen_square), .gen_piece(gen_piece),
      .gen_ack(gen_ack), .gen_move_valid(gen_move_valid), .gen_move(gen_move),
      .gen_done(gen_done), .res_we(res_we), .res_addr(res_addr), .res_wdata(res_wdata),
      .busy(busy), .done(done), .move_count(move_count), .overflow(overflow),
      .timeout_err(timeout_err)
   );

   // Board register file: data valid one cycle after the address.
   logic [31:0] board_mem [8];
   always @(posedge clk) board_rdata <= board_mem[board_addr];

   // Generator model settings and what it observed.
   int  ack_delay = 2;
   bit  ack_rand  = 1'b0;
   int  n_min = 0, n_max = 0;
   int  salt = 0, dstep = 11;
   bit  gaps = 1'b0;
   bit  gen_kill = 1'b0;
   logic [5:0] req_sq[$];
   logic [3:0] req_pc[$];
   int         req_n[$];
   logic [14:0] wr_addr[$];
   logic [31:0] wr_data[$];
   int          req_cycles = 0;

   function automatic logic [5:0] dest_of(input int sq, input int k);
      return 6'((sq * 5 + k * dstep + salt) % 64);
   endfunction

   initial begin : generator
      int phase, cnt, k, n, sq;
      gen_ack = 1'b0; gen_move_valid = 1'b0; gen_done = 1'b0; gen_move = 6'd0;
      phase = 0; cnt = 0; k = 0; n = 0; sq = 0;
      forever begin
         @(negedge clk);
         gen_ack = 1'b0; gen_move_valid = 1'b0; gen_done = 1'b0; gen_move = 6'd0;
         if (gen_kill) begin
            phase = 0;
         end else begin
            if (phase == 0 && gen_req === 1'b1) begin
               sq = int'(gen_square);
               req_sq.push_back(gen_square);
               req_pc.push_back(gen_piece);
               n = $urandom_range(n_max, n_min);
               req_n.push_back(n);
               cnt = ack_rand ? $urandom_range(ack_delay, 0) : ack_delay;
               k = 0;
               phase = 1;
            end
            if (phase == 1) begin
               if (cnt == 0) begin gen_ack = 1'b1; phase = 2; end
               else cnt--;
            end else if (phase == 2) begin
               if (!(gaps && $urandom_range(3, 0) == 0)) begin
                  if (k < n) begin gen_move_valid = 1'b1; gen_move = dest_of(sq, k); end
                  if (k >= n - 1) begin gen_done = 1'b1; phase = 0; end
                  k++;
               end
            end
         end
      end
   end

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (res_we === 1'b1) begin
            wr_addr.push_back(res_addr);
            wr_data.push_back(res_wdata);
         end
         if (gen_req === 1'b1) req_cycles++;
      end
   end

   initial begin : global_limit
      #900000;
      $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "global time limit");
   end

   // Reference model: own pieces in square order, then moves packed in order until the slots run out.
   logic [5:0]  exp_sq[$];
   logic [3:0]  exp_pc[$];
   logic [14:0] exp_addr[$];
   logic [31:0] exp_data[$];
   int          exp_count;
   bit          exp_ovf;

   task automatic build_model(input bit s);
      logic [31:0] w;
      logic [3:0]  nib;
      int          n;
      exp_sq.delete(); exp_pc.delete(); exp_addr.delete(); exp_data.delete();
      exp_count = 0; exp_ovf = 1'b0;
      for (int sq = 0; sq < 64; sq++) begin
         w   = board_mem[sq / 8];
         nib = w[4 * (sq % 8) +: 4];
         if (nib != 4'd0 && nib[3] == s) begin
            exp_sq.push_back(6'(sq));
            exp_pc.push_back(nib);
         end
      end
      for (int i = 0; i < exp_sq.size(); i++) begin
         n = (i < req_n.size()) ? req_n[i] : 0;
         for (int k = 0; k < n; k++) begin
            if (exp_count < MAX_MOVES) begin
               exp_addr.push_back(15'(MOVE_BASE + exp_count));
               exp_data.push_back({16'h0, exp_pc[i], exp_sq[i], dest_of(int'(exp_sq[i]), k)});
               exp_count++;
            end else begin
               exp_ovf = 1'b1;
            end
         end
      end
   endtask

   task automatic clear_logs();
      req_sq.delete(); req_pc.delete(); req_n.delete();
      wr_addr.delete(); wr_data.delete();
      req_cycles = 0;
   endtask

   task automatic pulse_start(input bit s);
      @(negedge clk);
      side = s; start = 1'b1; gen_kill = 1'b0;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Returns the cycle (1 = first cycle after start was sampled) where done is seen, -1 on expiry.
   task automatic wait_done(input int budget, input int restart_at, output int cyc, output int busy_cycles);
      cyc = -1; busy_cycles = 0;
      for (int i = 1; i <= budget; i++) begin
         if (i > 1) @(negedge clk);
         if (restart_at > 0) start = (i == restart_at);
         if (done === 1'b1) begin cyc = i; start = 1'b0; return; end
         if (busy === 1'b1) busy_cycles++;
      end
      start = 1'b0;
   endtask

   task automatic run_and_check(input string name, input bit s, input int exp_cyc);
      int cyc, bc;
      clear_logs();
      pulse_start(s);
      wait_done(30000, 0, cyc, bc);
      checks++;
      if (cyc < 0) begin errors++; $display("FAIL %s done_wait: done never seen, required within 30000 cycles", name); end
      if (exp_cyc > 0) begin
         checks++;
         if (cyc !== exp_cyc) begin errors++; $display("FAIL %s done_cycle: got %0d required %0d", name, cyc, exp_cyc); end
      end
      repeat (2) @(negedge clk);
      build_model(s);
      checks++;
      if (req_sq.size() !== exp_sq.size()) begin
         errors++; $display("FAIL %s req_count: got %0d required %0d", name, req_sq.size(), exp_sq.size());
      end
      for (int i = 0; i < req_sq.size() && i < exp_sq.size(); i++) begin
         checks++;
         if (req_sq[i] !== exp_sq[i] || req_pc[i] !== exp_pc[i]) begin
            errors++;
            $display("FAIL %s req[%0d]: got sq %0d piece %0d required sq %0d piece %0d",
                     name, i, req_sq[i], req_pc[i], exp_sq[i], exp_pc[i]);
         end
      end
      checks++;
      if (wr_addr.size() !== exp_addr.size()) begin
         errors++; $display("FAIL %s write_count: got %0d required %0d", name, wr_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < wr_addr.size() && i < exp_addr.size(); i++) begin
         checks++;
         if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
            errors++;
            $display("FAIL %s write[%0d]: got addr %0d data %h required addr %0d data %h",
                     name, i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
         end
      end
      checks++;
      if (move_count !== 8'(exp_count) || overflow !== exp_ovf || done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s status: got count %0d ovf %b done %b busy %b required count %0d ovf %b done 1 busy 0",
                  name, move_count, overflow, done, busy, exp_count, exp_ovf);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      checks++;
      if ({gen_req, res_we, busy, done, overflow, timeout_err, move_count, gen_square, gen_piece,
           board_addr, res_wdata} !== '0 || res_addr !== 15'(MOVE_BASE)) begin
         errors++;
         $display("FAIL %s outputs: got req %b we %b busy %b done %b ovf %b to %b cnt %0d sq %0d pc %0d baddr %0d waddr %0d wdata %h required all 0, res_addr %0d",
                  name, gen_req, res_we, busy, done, overflow, timeout_err, move_count, gen_square,
                  gen_piece, board_addr, res_addr, res_wdata, MOVE_BASE);
      end
   endtask

   task automatic clear_board();
      for (int w = 0; w < 8; w++) board_mem[w] = 32'h0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; abort = 1'b0; side = 1'b0;
      clear_board();
      repeat (3) @(negedge clk);
      check_reset_outputs("reset_held");
      reset = 1'b0;
      @(negedge clk);
      check_reset_outputs("reset_released");
   endtask

   task automatic test_empty_board();
      int cyc, bc;
      clear_board(); clear_logs();
      n_min = 0; n_max = 0; ack_rand = 1'b0; ack_delay = 2; gaps = 1'b0;
      pulse_start(1'b0);
      wait_done(200, 40, cyc, bc);
      checks++;
      if (cyc !== 81 || bc !== 80) begin
         errors++; $display("FAIL empty_timing: got done at %0d busy %0d cycles required 81 and 80", cyc, bc);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || req_cycles !== 0 || wr_addr.size() !== 0 || move_count !== 8'd0) begin
         errors++;
         $display("FAIL empty_status: got done %b busy %b reqs %0d writes %0d count %0d required 1 0 0 0 0",
                  done, busy, req_cycles, wr_addr.size(), move_count);
      end
   endtask

   task automatic test_piece_order();
      clear_board();
      board_mem[0] = 32'h42365324;
      n_min = 0; n_max = 0; ack_rand = 1'b0; ack_delay = 2; gaps = 1'b0;
      run_and_check("order_white", 1'b0, 0);
      run_and_check("order_black", 1'b1, 81);
   endtask

   task automatic test_knight_moves();
      clear_board();
      board_mem[0] = 32'h00000020;
      n_min = 2; n_max = 2; salt = 11; dstep = 2;
      run_and_check("knight", 1'b0, 0);
      checks++;
      if (wr_data.size() < 2 || wr_data[0] !== 32'h2050 || wr_data[1] !== 32'h2052 ||
          wr_addr[0] !== 15'd16 || wr_addr[1] !== 15'd17) begin
         errors++; $display("FAIL knight_literal: got %0d writes, required 0x2050@16 and 0x2052@17", wr_data.size());
      end
   endtask

   task automatic test_overflow();
      clear_board();
      board_mem[1] = 32'h00000400;
      n_min = 130; n_max = 130; salt = $urandom_range(63, 0); dstep = 7;
      gaps = 1'b1;
      run_and_check("overflow", 1'b0, 0);
      checks++;
      if (move_count !== 8'd128 || overflow !== 1'b1 || wr_addr.size() !== 128) begin
         errors++;
         $display("FAIL overflow_literal: got count %0d ovf %b writes %0d required 128 1 128",
                  move_count, overflow, wr_addr.size());
      end
   endtask

   task automatic random_board();
      logic [3:0] nib;
      for (int w = 0; w < 8; w++) begin
         for (int j = 0; j < 8; j++) begin
            if ($urandom_range(9, 0) < 5) nib = 4'd0;
            else nib = {1'($urandom_range(1, 0)), 3'($urandom_range(6, 1))};
            board_mem[w][4 * j +: 4] = nib;
         end
      end
   endtask

   task automatic test_random();
      for (int p = 0; p < 6; p++) begin
         random_board();
         n_min = 0; n_max = 4; ack_rand = 1'b1; ack_delay = 3; gaps = 1'b1;
         salt = $urandom_range(63, 0); dstep = $urandom_range(13, 1);
         run_and_check($sformatf("random%0d", p), 1'($urandom_range(1, 0)), 0);
      end
   endtask

   task automatic test_abort();
      int held, reqs_held;
      logic [7:0] cnt_held;
      bit reached;
      random_board();
      board_mem[0][3:0] = 4'h5;
      n_min = 20; n_max = 20; ack_rand = 1'b0; ack_delay = 1; gaps = 1'b1;
      clear_logs();
      pulse_start(1'b0);
      reached = 1'b0;
      for (int i = 0; i < 2000 && !reached; i++) begin
         @(negedge clk);
         if (wr_addr.size() >= 3) reached = 1'b1;
      end
      checks++;
      if (!reached) begin errors++; $display("FAIL abort_setup: got %0d writes, required 3 within 2000 cycles", wr_addr.size()); end
      abort = 1'b1; gen_kill = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      held = wr_addr.size(); reqs_held = req_cycles; cnt_held = move_count;
      checks++;
      if (busy !== 1'b0 || gen_req !== 1'b0 || done !== 1'b0 || res_we !== 1'b0 || move_count !== 8'(held)) begin
         errors++;
         $display("FAIL abort_state: got busy %b req %b done %b we %b count %0d required 0 0 0 0 count %0d",
                  busy, gen_req, done, res_we, move_count, held);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (wr_addr.size() !== held || req_cycles !== reqs_held || move_count !== cnt_held || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_hold: got writes %0d reqs %0d count %0d busy %b required %0d %0d %0d 0",
                  wr_addr.size(), req_cycles, move_count, busy, held, reqs_held, cnt_held);
      end
      n_min = 0; n_max = 3; gaps = 1'b1;
      run_and_check("after_abort", 1'b0, 0);
   endtask

   task automatic test_reset_mid_pass();
      random_board();
      n_min = 1; n_max = 3;
      clear_logs();
      pulse_start(1'b1);
      repeat (30) @(negedge clk);
      reset = 1'b1; gen_kill = 1'b1;
      @(negedge clk);
      check_reset_outputs("reset_mid_pass");
      @(negedge clk);
      reset = 1'b0;
      run_and_check("after_reset", 1'b1, 0);
   endtask

   initial begin
      test_reset();
      test_empty_board();
      test_piece_order();
      test_knight_moves();
      test_overflow();
      test_random();
      test_abort();
      test_reset_mid_pass();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
